aes_128_key_sched: RTL
======================

Name: aes_128_key_sched

Overview:
Round-key scheduler for the 128-bit AES core with its 3-cycle round and 4-BRAM S-box. It holds the 11 expanded round keys, loaded by a host write port. It presents round key 0 while idle and steps through round keys 1..10 on each key_ready strobe from the core. It tracks block starts (in_en) and completion (out_en) and locks the key store while encryption is in flight.

Parameters:
NR, 10, number of AES rounds; the store holds NR+1 keys.
KW, 128, key/round-key width in bits.

Ports:
clk  in  1  system clock, rising edge.
kill  in  1  asynchronous active-low reset.
key_wr_en  in  1  host write strobe into the key store.
key_wr_addr  in  4  round-key index, 0..NR.
key_wr_data  in  KW  round-key value.
key_clr  in  1  invalidates all stored keys (valid mask := 0).
in_en  in  1  block-input strobe to the core, snooped.
key_ready  in  1  core request for the next round key.
out_en  in  1  core output-valid strobe, snooped.
key_round  out  KW  round key driven to the core, registered.
key_valid  out  1  all NR+1 keys written since the last clear/reset.
busy  out  1  high in RUN state.
round_idx  out  4  index of the key currently on key_round.
err  out  1  single-cycle error pulse, registered.

Behaviour:
- Reset (kill=0, async): state=IDLE; key store contents undefined (no reset needed); valid mask=0; key_round=0; round_idx=0; busy=0; err=0; key_valid=0.
- Key store: 11 x KW registers with an 11-bit valid mask. key_valid = AND of the mask, registered with the mask.
- Writes are accepted only in IDLE:
  - Sets mask[addr]; the written data is readable from the next cycle.
  - Write with addr>NR: ignored, err pulses.
  - Write in RUN: ignored, err pulses.
  - key_clr in either state: mask cleared next edge. key_clr has priority over a same-cycle write.
- IDLE:
  - Every cycle, key_round <= rk[0], round_idx <= 0.
  - A write to addr 0 appears on key_round 2 cycles after the strobe (store update, then output register).
  - in_en with key_valid=1: go to RUN, internal idx<=1. If key_ready is also high that cycle, key_round<=rk[1], round_idx<=1, idx<=2.
  - in_en with key_valid=0: stay IDLE, err pulses.
  - key_ready in IDLE: ignored, no error.
- RUN (busy=1):
  - key_ready and idx<=NR: key_round<=rk[idx], round_idx<=idx, idx<=idx+1. Latency is 1 cycle from the key_ready edge to the new key_round.
  - key_ready with idx>NR (overrun): key_round holds, err pulses.
  - in_en in RUN (pipelined next block): idx<=1, then the key_ready rule applies in the same cycle using idx=1. key_round is otherwise unchanged.
  - out_en: next edge go to IDLE, key_round<=rk[0], round_idx<=0. If in_en is high in the same cycle, in_en wins: stay in RUN with idx handling as above.
  - out_en and key_ready in the same cycle with no in_en: out_en wins and the key request is dropped.
  - Without out_en, no timeout: stays in RUN.
- The key store is never written during RUN, so key_round is stable between key_ready strobes.
- Mid-operation reset: immediate IDLE, all outputs return to reset values, mask cleared; the host must reload keys.
- err: OR of all error sources in that cycle; high for exactly 1 cycle per offending cycle.

Test Plan:
1. Reset, then write rk0=0f0e0d0c0b0a09080706050403020100 and rk1..rk10 = fe76abd6f178a6dafa72afd2fd74aad6 .. c5302b4d8ba707f3174a94e37f1d1113 -> key_valid=1 after the last write; key_round=0f0e...0100, busy=0.
2. in_en one cycle, then 10 key_ready pulses spaced 3 cycles apart -> key_round=fe76abd6... one cycle after the first pulse, c5302b4d... after the tenth, round_idx 1..10. out_en -> key_round=0f0e...0100, busy=0.
3. in_en on 3 consecutive cycles followed by the key_ready sequence -> idx restarts on each in_en. The first key_ready after the last in_en yields rk1. No err.
4. 11th key_ready before out_en -> key_round holds c5302b4d..., err=1 for one cycle.
5. Write addr 3 during RUN, write addr 12 in IDLE, and in_en after key_clr -> err pulses each time; the store is unchanged in the first two cases; the state stays IDLE in the third.
6. Assert kill low mid-RUN (after round 5) -> key_round=0, busy=0, key_valid=0 immediately. After reload, a new run reproduces scenario 2 values.

Source files
------------

// File: rtl/aes_128_key_sched.sv
// aes_128_key_sched
// Round-key scheduler for the 128-bit AES core. Holds the NR+1 expanded
// round keys written by the host and hands them to the core one at a time.
// While idle it presents round key 0. After a block start (in_en) it moves
// to the next round key on each key_ready request from the core. A block
// completion (out_en) returns it to idle. The key store is locked while a
// block is in flight.
//
// Ports:
//   clk          system clock, rising edge
//   kill         asynchronous active-low reset
//   key_wr_en    host write strobe into the key store
//   key_wr_addr  round-key index being written, 0..NR
//   key_wr_data  round-key value being written
//   key_clr      invalidates every stored key
//   in_en        block-input strobe to the core (snooped)
//   key_ready    core request for the next round key
//   out_en       core output-valid strobe (snooped)
//   key_round    registered round key driven to the core
//   key_valid    all NR+1 keys written since the last clear/reset
//   busy         high while a block is in flight
//   round_idx    index of the key currently on key_round
//   err          registered single-cycle error pulse
module aes_128_key_sched #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          kill,
    input  logic          key_wr_en,
    input  logic [3:0]    key_wr_addr,
    input  logic [KW-1:0] key_wr_data,
    input  logic          key_clr,
    input  logic          in_en,
    input  logic          key_ready,
    input  logic          out_en,
    output logic [KW-1:0] key_round,
    output logic          key_valid,
    output logic          busy,
    output logic [3:0]    round_idx,
    output logic          err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] NR_IDX = 4'(NR);

    state_t        state, state_nxt;
    logic [KW-1:0] rk [0:NR];
    logic [NR:0]   mask, mask_nxt;
    logic [3:0]    idx, idx_nxt, idx_eff;
    logic [KW-1:0] key_round_nxt;
    logic [3:0]    round_idx_nxt;
    logic          err_nxt;
    logic          addr_ok;
    logic          wr_ok;
    logic          advance;

    assign addr_ok = (key_wr_addr <= NR_IDX);
    // A clear in the same cycle suppresses the write entirely.
    assign wr_ok   = key_wr_en && addr_ok && (state == IDLE) && !key_clr;
    assign busy    = (state == RUN);

    // The key store itself needs no reset; the valid mask says what is usable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            rk[key_wr_addr] <= key_wr_data;
        end
    end

    // Next-state and output logic. "advance" marks the cycles in which a
    // key_ready request is served against idx_eff: idx_eff is the running
    // index, or 1 when a new block starts in this cycle.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        idx_eff       = idx;
        key_round_nxt = key_round;
        round_idx_nxt = round_idx;
        mask_nxt      = mask;
        err_nxt       = 1'b0;
        advance       = 1'b0;

        if (key_clr) begin
            mask_nxt = '0;
        end else if (wr_ok) begin
            mask_nxt[key_wr_addr] = 1'b1;
        end

        if (key_wr_en && (!addr_ok || state == RUN)) begin
            err_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                key_round_nxt = rk[0];
                round_idx_nxt = 4'd0;
                if (in_en) begin
                    if (key_valid) begin
                        state_nxt = RUN;
                        idx_eff   = 4'd1;
                        advance   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                // A new block start outranks completion of the previous one.
                if (in_en) begin
                    idx_eff = 4'd1;
                    advance = 1'b1;
                end else if (out_en) begin
                    state_nxt     = IDLE;
                    key_round_nxt = rk[0];
                    round_idx_nxt = 4'd0;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (advance) begin
            idx_nxt = idx_eff;
            if (key_ready) begin
                if (idx_eff <= NR_IDX) begin
                    key_round_nxt = rk[idx_eff];
                    round_idx_nxt = idx_eff;
                    idx_nxt       = idx_eff + 4'd1;
                end else begin
                    // Overrun: the core asked for more keys than exist.
                    err_nxt = 1'b1;
                end
            end
        end
    end

    // State and output registers. key_valid is derived from the same next
    // mask so it changes on the same edge as the mask.
    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            state     <= IDLE;
            idx       <= 4'd0;
            key_round <= '0;
            round_idx <= 4'd0;
            mask      <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            key_round <= key_round_nxt;
            round_idx <= round_idx_nxt;
            mask      <= mask_nxt;
            key_valid <= &mask_nxt;
            err       <= err_nxt;
        end
    end

endmodule
